// File: rtl/asyn_controller_pkg.sv
// Shared opcode constants, state/request types and opcode classification helpers.
// ASYN_CTRL_ITYPE_EN adds the I-type ALU opcode to the legal instruction set.
package asyn_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEMWB   = 3'd4
  } state_e;

  typedef struct packed {
    logic req1;
    logic req2_1;
    logic req2_2;
    logic req3;
    logic req4;
  } req_t;

  // X/Z opcodes match no case item and fall to default, i.e. illegal.
  function automatic logic op_legal(input logic [6:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_BRANCH, OP_STORE, OP_LOAD: r = 1'b1;
`ifdef ASYN_CTRL_ITYPE_EN
      OP_ITYPE: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_BRANCH, OP_STORE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_has_memwb(input logic [6:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_STORE, OP_LOAD: r = 1'b1;
`ifdef ASYN_CTRL_ITYPE_EN
      OP_ITYPE: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic req_t stage_reqs(input state_e st, input logic [6:0] op);
    req_t r;
    r = '0;
    case (st)
      FETCH:   r.req1 = 1'b1;
      DECODE: begin
        r.req2_1 = 1'b1;
        r.req2_2 = op_reads_rs2(op);
      end
      EXECUTE: r.req3 = 1'b1;
      MEMWB:   r.req4 = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/asyn_controller_if.sv
// Run-control and request bundle between the instruction source and the sequencer.
interface asyn_controller_if;
  logic       set;
  logic [6:0] opcode;
  logic       req1;
  logic       req2_1;
  logic       req2_2;
  logic       req3;
  logic       req4;

  modport master (
    output set, opcode,
    input  req1, req2_1, req2_2, req3, req4
  );

  modport slave (
    input  set, opcode,
    output req1, req2_1, req2_2, req3, req4
  );
endinterface

// File: rtl/asyn_controller_stage_timer.sv
// Phase counter for one sequencer stage; done marks the last cycle of the stage.
module stage_timer #(
  parameter int unsigned STAGE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  logic [3:0] count_q, count_d;

  assign done = (count_q == 4'(STAGE_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (!done)
      count_d = count_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/asyn_controller.sv
// Multi-cycle instruction sequencer issuing fetch/decode/execute/memwb requests.
// Optional I-type support is enabled with ASYN_CTRL_ITYPE_EN.
module asyn_controller_seq
  import asyn_ctrl_pkg::*;
#(
  parameter int unsigned STAGE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  asyn_controller_if.slave   bus
);

  state_e     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  req_t       req_q, req_d;
  logic       stage_done;
  logic       stage_clr;

  stage_timer #(.STAGE_CYCLES(STAGE_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (stage_clr),
    .done (stage_done)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    case (state_q)
      IDLE: begin
        if (bus.set) begin
          opc_d   = bus.opcode;
          state_d = FETCH;
        end
      end
      FETCH:   if (stage_done) state_d = op_legal(opc_q) ? DECODE : IDLE;
      DECODE:  if (stage_done) state_d = EXECUTE;
      EXECUTE: if (stage_done) state_d = op_has_memwb(opc_q) ? MEMWB : IDLE;
      MEMWB:   if (stage_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Holding the timer clear in IDLE means every stage starts counting from zero.
  assign stage_clr = (state_d != state_q) || (state_q == IDLE);

  // Requests are decoded from the next state so the registered outputs line up
  // exactly with the state they describe.
  assign req_d = stage_reqs(state_d, opc_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      req_q   <= req_d;
    end
  end

  assign bus.req1   = req_q.req1;
  assign bus.req2_1 = req_q.req2_1;
  assign bus.req2_2 = req_q.req2_2;
  assign bus.req3   = req_q.req3;
  assign bus.req4   = req_q.req4;

endmodule

module asyn_controller #(
  parameter int unsigned STAGE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [6:0] opcode,
  output logic       req1,
  output logic       req2_1,
  output logic       req2_2,
  output logic       req3,
  output logic       req4
);

  asyn_controller_if ctrl_bus ();

  assign ctrl_bus.set    = set;
  assign ctrl_bus.opcode = opcode;
  assign req1            = ctrl_bus.req1;
  assign req2_1          = ctrl_bus.req2_1;
  assign req2_2          = ctrl_bus.req2_2;
  assign req3            = ctrl_bus.req3;
  assign req4            = ctrl_bus.req4;

  asyn_controller_seq #(.STAGE_CYCLES(STAGE_CYCLES)) u_seq (
    .clk (clk),
    .rst (reset),
    .bus (ctrl_bus.slave)
  );

endmodule

// File: tb/tb_asyn_controller.sv
// Randomized bench for asyn_controller against a per-instruction request-sequence model.
module tb_asyn_controller;

  localparam int unsigned SC = 2;

  typedef logic [4:0] vec_t;   // {req1, req2_1, req2_2, req3, req4}
  typedef vec_t vq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  vq_t  exp_q;
  vec_t cur = '0;

  asyn_controller_if bus ();

  asyn_controller #(.STAGE_CYCLES(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .set    (bus.set),
    .opcode (bus.opcode),
    .req1   (bus.req1),
    .req2_1 (bus.req2_1),
    .req2_2 (bus.req2_2),
    .req3   (bus.req3),
    .req4   (bus.req4)
  );

  always #5 clk = ~clk;

  // Expected output for every cycle of one instruction, plus the idle gap after it.
  function automatic vq_t build_seq(input logic [6:0] op);
    vq_t st;
    vq_t s;
    st.push_back(5'b10000);
    if (op === 7'b0110011 || op === 7'b0100011 || op === 7'b1100011) begin
      st.push_back(5'b01100);
      st.push_back(5'b00010);
      if (op !== 7'b1100011) st.push_back(5'b00001);
    end else if (op === 7'b0000011) begin
      st.push_back(5'b01000);
      st.push_back(5'b00010);
      st.push_back(5'b00001);
    end
`ifdef ASYN_CTRL_ITYPE_EN
    else if (op === 7'b0010011) begin
      st.push_back(5'b01000);
      st.push_back(5'b00010);
      st.push_back(5'b00001);
    end
`endif
    foreach (st[i])
      for (int unsigned k = 0; k < SC; k++) s.push_back(st[i]);
    s.push_back(5'b00000);
    return s;
  endfunction

  function automatic vec_t dut_vec();
    return {bus.req1, bus.req2_1, bus.req2_2, bus.req3, bus.req4};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_at(input int n, input vec_t expv, input string name);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    check(name, dut_vec(), expv);
  endtask

  // Reference model and per-cycle compare.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        cur = '0;
      end else begin
        if (exp_q.size() == 0 && bus.set) exp_q = build_seq(bus.opcode);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
      end
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        cur = '0;
      end
      check("cycle", dut_vec(), cur);
      check("onehot", 32'($onehot0({bus.req1, bus.req2_1, bus.req3, bus.req4})), 32'd1);
    end
  end

  initial begin
    vq_t s;
    logic [6:0] ops [8];
    int rst_left;
    bit found;

    ops[0] = 7'b0110011; ops[1] = 7'b1100011; ops[2] = 7'b0100011; ops[3] = 7'b0000011;
    ops[4] = 7'b0010011; ops[5] = 7'b1111111; ops[6] = 7'b0000000; ops[7] = 7'b1010101;

    // Pin the model against hand-derived sequences.
    s = build_seq(7'b0110011);
    check("model_r_len", 32'(s.size()), 32'd9);
    check("model_r_dec", 32'(s[2]), 32'b01100);
    check("model_r_gap", 32'(s[8]), 32'b00000);
    s = build_seq(7'b1100011);
    check("model_b_len", 32'(s.size()), 32'd7);
    s = build_seq(7'b0000011);
    check("model_l_dec", 32'(s[3]), 32'b01000);
    check("model_l_wb", 32'(s[6]), 32'b00001);
    s = build_seq(7'b1111111);
    check("model_ill_len", 32'(s.size()), 32'd3);

    bus.set = 1'b1;
    bus.opcode = 'x;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_idle", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    bus.opcode = 7'b0110011;

    chk_at(1, 5'b10000, "rtype_fetch");
    chk_at(2, 5'b01100, "rtype_decode");
    chk_at(2, 5'b00010, "rtype_exec");
    chk_at(2, 5'b00001, "rtype_memwb");
    chk_at(2, 5'b00000, "rtype_gap");
    chk_at(1, 5'b10000, "rtype_refetch");
    bus.opcode = 7'b1100011;
    chk_at(6, 5'b00001, "switch_memwb");
    chk_at(2, 5'b00000, "switch_gap");
    chk_at(3, 5'b01100, "branch_decode");
    chk_at(4, 5'b00000, "branch_no_memwb");

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #3;
      if (bus.req3) found = 1'b1;
    end
    check("wait_exec", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_async", 32'(dut_vec()), 32'd0);
    bus.opcode = 7'b0100011;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    chk_at(1, 5'b10000, "restart_fetch");
    chk_at(2, 5'b01100, "store_decode");

    rst_left = 0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #3;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 59) == 0) rst_left = int'($urandom_range(1, 2));
      reset = (rst_left > 0);
      bus.set = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.opcode = ops[$urandom_range(0, 7)];
        if (bus.opcode == 7'b1010101) bus.opcode = 7'($urandom);
      end
    end

    reset = 1'b0;
    bus.set = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_idle", 32'(dut_vec()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asyn_controller.md
ASYN_CONTROLLER -- requirements
Module: asyn_controller

Interface
- REQ-001 SHALL have parameter STAGE_CYCLES, default 2, number of clock cycles each request phase stays asserted (legal 1..15).
- REQ-002 SHALL have port clk, input, 1, single rising-edge clock for all state.
- REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-004 SHALL have port set, input, 1, run enable; high = issue instructions back to back.
- REQ-005 SHALL have port opcode, input, 7, RISC-V major opcode of the instruction to sequence.
- REQ-006 SHALL have port req1, output, 1, fetch request.
- REQ-007 SHALL have port req2_1, output, 1, decode/rs1 register-read request.
- REQ-008 SHALL have port req2_2, output, 1, rs2 register-read request.
- REQ-009 SHALL have port req3, output, 1, execute request.
- REQ-010 SHALL have port req4, output, 1, memory/write-back request.

Function
- REQ-011 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, MEMWB.
- REQ-012 In IDLE, with set=1 sampled at a rising edge: SHALL latch opcode and enter FETCH. With set=0: SHALL stay in IDLE.
- REQ-013 Each non-IDLE state SHALL last exactly STAGE_CYCLES cycles, counted by a phase counter cleared on every state entry.
- REQ-014 Outputs SHALL be registered, and SHALL be a function of the current state and latched opcode only.
- REQ-015 FETCH: req1=1. DECODE: req2_1=1. EXECUTE: req3=1. MEMWB: req4=1. All other outputs 0 in each state.
- REQ-016 DECODE SHALL also assert req2_2 for R-type 0110011, branch 1100011 and store 0100011, and SHALL NOT assert it for load 0000011.
- REQ-017 Stage paths:
  - R-type, store, load: FETCH, DECODE, EXECUTE, MEMWB, IDLE.
  - Branch: FETCH, DECODE, EXECUTE, IDLE (no req4).
- REQ-018 Any other opcode, including X or Z, SHALL be illegal: FETCH only, then IDLE.
- REQ-019 Opcode changes after latching SHALL NOT affect the instruction in flight.
- REQ-020 set deasserted mid-instruction: the instruction SHALL complete; the FSM then idles.
- REQ-021 With set held high, the FSM SHALL spend exactly one cycle in IDLE between instructions, then latch the current opcode.
- REQ-022 At most one of req1, req2_1, req3, req4 SHALL be high in any cycle.

Reset
- REQ-023 reset=1 SHALL immediately force state IDLE, phase counter 0, latched opcode 0, and all req outputs 0, regardless of clk.
- REQ-024 Reset asserted mid-instruction SHALL abort the instruction with no further requests issued.
- REQ-025 After reset release, the first start SHALL occur at the first rising edge with set=1.
- REQ-026 set SHALL be ignored while reset=1.

Configuration
- REQ-027 Macro ASYN_CTRL_ITYPE_EN, when defined, SHALL add I-type ALU opcode 0010011 with path FETCH, DECODE (req2_1 only), EXECUTE, MEMWB, IDLE.
- REQ-028 Without ASYN_CTRL_ITYPE_EN, opcode 0010011 SHALL be treated as illegal.

Structure
- REQ-029 Package asyn_ctrl_pkg SHALL hold the opcode constants (OP_RTYPE, OP_BRANCH, OP_STORE, OP_LOAD, OP_ITYPE) and the state enum typedef.
- REQ-030 Sub-module stage_timer SHALL implement the phase counter, with a clear-on-entry input and a done output at count STAGE_CYCLES-1.

Verification (STAGE_CYCLES=2)
- REQ-031 Reset: reset=1 with opcode=X -> all req outputs 0; no activity.
- REQ-032 R-type: set=1, opcode=0110011 -> req1 for 2 cycles, req2_1 and req2_2 together for 2, req3 for 2, req4 for 2, 1 idle cycle, then repeat.
- REQ-033 Branch: opcode=1100011 -> req1, req2_1+req2_2, req3 (2 cycles each); req4 never high.
- REQ-034 Load and store:
  - Load 0000011 -> req2_2 stays 0, req4 2 cycles.
  - Store 0100011 -> req2_2 high with req2_1.
- REQ-035 Opcode switched from 0110011 to 1100011 mid-instruction -> current R-type completes with req4; the next instruction follows the branch path.
- REQ-036 Reset pulse during EXECUTE -> outputs 0 within the same cycle; the FSM restarts from FETCH after release with set=1.
